// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select, IF/ID register; 1-cycle fetch latency,
// stalls via pcwrite_hz/ifidwrite_hz, EX redirect flushes one slot. Perf counters under IF_PERF_CNT_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pcwrite_hz,
    input  logic        ifidwrite_hz,
    input  logic        branch_taken_ex,
    input  logic [31:0] branch_target_ex,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_id,
    output logic [31:0] pc_plus4_id,
    output logic [31:0] instr_id,
    output logic        valid_id,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    logic [31:0] r_pc_if;
    logic [31:0] r_pc_id;
    logic [31:0] r_pc_plus4_id;
    logic [31:0] r_instr_id;
    logic        r_valid_id;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_pc;

    assign w_pc_plus4    = r_pc_if + 32'd4;
    assign w_redirect_pc = {branch_target_ex[31:2], 2'b00};

    // Redirect wins over a stall so a squashed fetch can never be replayed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_if <= RESET_PC;
        end else if (branch_taken_ex) begin
            r_pc_if <= w_redirect_pc;
        end else if (pcwrite_hz) begin
            r_pc_if <= w_pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_id       <= 32'h0;
            r_pc_plus4_id <= 32'h0;
            r_instr_id    <= NOP_INSTR;
            r_valid_id    <= 1'b0;
        end else if (branch_taken_ex) begin
            r_instr_id <= NOP_INSTR;
            r_valid_id <= 1'b0;
        end else if (ifidwrite_hz) begin
            r_pc_id       <= r_pc_if;
            r_pc_plus4_id <= w_pc_plus4;
            r_instr_id    <= imem_rdata;
            r_valid_id    <= 1'b1;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'h0;
            r_flush_cnt <= 32'h0;
        end else begin
            if (!pcwrite_hz && !branch_taken_ex && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (branch_taken_ex && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = 32'h0;
    assign flush_cnt = 32'h0;
`endif

    assign imem_addr   = r_pc_if;
    assign pc_id       = r_pc_id;
    assign pc_plus4_id = r_pc_plus4_id;
    assign instr_id    = r_instr_id;
    assign valid_id    = r_valid_id;

endmodule
